// File: rtl/frame_pixel_streamer.sv
// Raster-order frame reader: issues one memory read per non-paused cycle,
// emits registered pixel beats two cycles later, then zero flush beats to drain the line buffer.
module frame_pixel_streamer #(
  parameter int NUM_CHANNELS = 8,
  parameter int DATA_WIDTH   = 8,
  parameter int IMG_WIDTH    = 256,
  parameter int IMG_HEIGHT   = 256,
  parameter int ADDR_WIDTH   = 16,
  parameter int FLUSH_LEN    = 258
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 i_start,
  input  logic [ADDR_WIDTH-1:0]                i_base_addr,
  input  logic                                 i_pause,
  output logic                                 o_mem_rd_en,
  output logic [ADDR_WIDTH-1:0]                o_mem_addr,
  input  logic [NUM_CHANNELS*DATA_WIDTH-1:0]   i_mem_rdata,
  output logic                                 o_valid,
  output logic [NUM_CHANNELS*DATA_WIDTH-1:0]   o_data,
  output logic                                 o_sof,
  output logic                                 o_eol,
  output logic                                 o_flush,
  output logic                                 o_busy,
  output logic                                 o_done
);

  localparam int BEAT_W = NUM_CHANNELS * DATA_WIDTH;
  localparam int COL_W  = $clog2(IMG_WIDTH);
  localparam int ROW_W  = $clog2(IMG_HEIGHT);
  localparam int FL_W   = $clog2(FLUSH_LEN + 2);

  localparam logic [COL_W-1:0] LAST_COL   = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0] LAST_ROW   = ROW_W'(IMG_HEIGHT - 1);
  localparam logic [FL_W-1:0]  LAST_FLUSH = FL_W'((FLUSH_LEN > 0) ? FLUSH_LEN - 1 : 0);

  typedef enum logic [1:0] {IDLE, STREAM, FLUSH, DRAIN} state_t;

  state_t                state_q, state_d;
  logic [COL_W-1:0]      col_q;
  logic [ROW_W-1:0]      row_q;
  logic [FL_W-1:0]       flush_cnt_q;
  logic [ADDR_WIDTH-1:0] next_addr_q;

  // Beat metadata travels alongside the read: stage 1 = issue, stage 2 = memory cycle.
  logic s1_valid_q, s1_sof_q, s1_eol_q, s1_flush_q;
  logic s2_valid_q, s2_sof_q, s2_eol_q, s2_flush_q;

  logic start_ok, issue_pix, issue_flush, last_pix, last_flush, pipe_empty;
  logic busy_d, done_d;

  assign last_pix   = (row_q == LAST_ROW) && (col_q == LAST_COL);
  assign last_flush = (flush_cnt_q == LAST_FLUSH);
  assign pipe_empty = !s1_valid_q && !s2_valid_q;

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:   if (i_start) state_d = STREAM;
      STREAM: if (!i_pause && last_pix) state_d = (FLUSH_LEN == 0) ? DRAIN : FLUSH;
      FLUSH:  if (!i_pause && last_flush) state_d = DRAIN;
      DRAIN:  if (pipe_empty) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    start_ok    = (state_q == IDLE) && i_start;
    issue_pix   = (state_q == STREAM) && !i_pause;
    issue_flush = (state_q == FLUSH) && !i_pause;
    done_d      = (state_q == DRAIN) && pipe_empty;
    busy_d      = (state_d != IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col_q       <= '0;
      row_q       <= '0;
      flush_cnt_q <= '0;
      next_addr_q <= '0;
      o_mem_rd_en <= 1'b0;
      o_mem_addr  <= '0;
      s1_valid_q  <= 1'b0;
      s1_sof_q    <= 1'b0;
      s1_eol_q    <= 1'b0;
      s1_flush_q  <= 1'b0;
      s2_valid_q  <= 1'b0;
      s2_sof_q    <= 1'b0;
      s2_eol_q    <= 1'b0;
      s2_flush_q  <= 1'b0;
      o_valid     <= 1'b0;
      o_data      <= '0;
      o_sof       <= 1'b0;
      o_eol       <= 1'b0;
      o_flush     <= 1'b0;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
    end else begin
      if (start_ok) begin
        col_q       <= '0;
        row_q       <= '0;
        flush_cnt_q <= '0;
        next_addr_q <= i_base_addr;
      end
      if (issue_pix) begin
        next_addr_q <= next_addr_q + ADDR_WIDTH'(1);
        o_mem_addr  <= next_addr_q;
        if (col_q == LAST_COL) begin
          col_q <= '0;
          row_q <= row_q + ROW_W'(1);
        end else begin
          col_q <= col_q + COL_W'(1);
        end
      end
      if (issue_flush) flush_cnt_q <= flush_cnt_q + FL_W'(1);

      o_mem_rd_en <= issue_pix;
      s1_valid_q  <= issue_pix || issue_flush;
      s1_sof_q    <= issue_pix && (row_q == '0) && (col_q == '0);
      s1_eol_q    <= issue_pix && (col_q == LAST_COL);
      s1_flush_q  <= issue_flush;

      s2_valid_q  <= s1_valid_q;
      s2_sof_q    <= s1_sof_q;
      s2_eol_q    <= s1_eol_q;
      s2_flush_q  <= s1_flush_q;

      o_valid     <= s2_valid_q;
      o_sof       <= s2_sof_q;
      o_eol       <= s2_eol_q;
      o_flush     <= s2_flush_q;
      o_data      <= (s2_valid_q && !s2_flush_q) ? i_mem_rdata : BEAT_W'(0);

      o_busy      <= busy_d;
      o_done      <= done_d;
    end
  end

endmodule
